// File: rtl/otter_cache_pkg.sv
// -----------------------------------------------------------------------------
// otter_cache_pkg
// Shared types and geometry helpers for the OTTER set-associative data cache.
//   state_t      : miss FSM states (IDLE, WB, FILL)
//   *_bits()     : field widths derived from the cache geometry
//   line_t       : one cache line at the default geometry, word 0 in the LSBs
// -----------------------------------------------------------------------------
package otter_cache_pkg;

    localparam int WORD_BITS      = 32;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    typedef logic [DEF_LINE_WORDS-1:0][WORD_BITS-1:0] line_t;

    // Word-offset field width: address bits [offset_bits+1:2].
    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int line_words, input int sets);
        return 32 - 2 - offset_bits(line_words) - index_bits(sets);
    endfunction

    // Way-number width; a direct-mapped cache still carries a 1-bit way id.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/otter_cache_lru.sv
// -----------------------------------------------------------------------------
// otter_cache_lru
// True-LRU age tracking for every set: victim selection and age update.
//   clk, rst_n       : clock, async active-low reset (all ages -> 0)
//   lookup_set       : set being looked up this cycle
//   lookup_valid     : valid bits of that set, one per way
//   victim           : lowest-index invalid way, else the oldest way
//   touch_en         : a hit or a fill touches touch_way of touch_set
//   touch_was_valid  : the touched way held a valid line before the touch
// With WAYS = 1 no age state exists and the victim is always way 0.
// -----------------------------------------------------------------------------
module otter_cache_lru
    import otter_cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 16,
    localparam int WAY_W = way_bits(WAYS),
    localparam int IDX_W = index_bits(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_set,
    input  logic [WAYS-1:0]  lookup_valid,
    output logic [WAY_W-1:0] victim,
    input  logic             touch_en,
    input  logic [IDX_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             touch_was_valid
);

    if (WAYS == 1) begin : g_direct
        logic unused_lru;
        assign unused_lru = ^{lookup_set, lookup_valid, touch_en, touch_set,
                              touch_way, touch_was_valid};
        assign victim     = '0;
    end else begin : g_lru
        localparam int AGE_W = $clog2(WAYS);

        logic [AGE_W-1:0] age_q [SETS][WAYS];
        logic [AGE_W-1:0] max_age;
        logic [AGE_W-1:0] old_age;

        // NOTE: every variable assigned in always_comb gets a default first,
        //       otherwise paths that skip the assignment infer a latch.
        always_comb begin
            victim  = '0;
            max_age = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[lookup_set][w] > max_age) begin
                    max_age = age_q[lookup_set][w];
                    victim  = WAY_W'(w);
                end
            end
            // Invalid ways win; scanning downward leaves the lowest one.
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!lookup_valid[w]) victim = WAY_W'(w);
            end
        end

        // A way that held nothing is treated as the oldest, so the valid ways
        // of a set always hold a permutation of 0..k-1 even though reset
        // zeroes every age.
        assign old_age = touch_was_valid ? age_q[touch_set][touch_way]
                                         : AGE_W'(WAYS - 1);

        // NOTE: state is updated with non-blocking assignments so every flop
        //       samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
                end
            end else if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_q[touch_set][w] <= '0;
                    else if (age_q[touch_set][w] < old_age)
                        age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/otter_dcache_sa.sv
// -----------------------------------------------------------------------------
// otter_dcache_sa
// N-way set-associative, write-back, write-allocate data cache for OTTER.
// Owns its miss FSM, true-LRU replacement and the core stall output.
//   clk, rst_n        : clock, async active-low reset
//   req_valid/we/addr/wdata/be : core data port (byte address, lane-aligned)
//   rsp_data          : loaded word on a hit, 0 otherwise
//   stall             : core holds its request while high
//   mem_req/we/addr   : line transfer to backing memory (we=1 write-back)
//   mem_wline, mem_rline, mem_ack : line data out/in, one-cycle completion
// Optional: define OTTER_DCACHE_STATS_EN to add hit_cnt / miss_cnt outputs.
// -----------------------------------------------------------------------------
module otter_dcache_sa
    import otter_cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [31:0]                    req_addr,
    input  logic [31:0]                    req_wdata,
    input  logic [3:0]                     req_be,
    output logic [31:0]                    rsp_data,
    output logic                           stall,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [31:0]                    mem_addr,
    output logic [WORD_BITS*LINE_WORDS-1:0] mem_wline,
    input  logic [WORD_BITS*LINE_WORDS-1:0] mem_rline,
    input  logic                           mem_ack
`ifdef OTTER_DCACHE_STATS_EN
    ,
    output logic [31:0]                    hit_cnt,
    output logic [31:0]                    miss_cnt
`endif
);

    localparam int OFF_W = offset_bits(LINE_WORDS);
    localparam int IDX_W = index_bits(SETS);
    localparam int TAG_W = tag_bits(LINE_WORDS, SETS);
    localparam int WAY_W = way_bits(WAYS);

    typedef logic [LINE_WORDS-1:0][WORD_BITS-1:0] cline_t;

    // Line state and contents
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    cline_t           data_q  [SETS][WAYS];

    // Miss FSM
    state_t           state_q;
    logic [IDX_W-1:0] set_q;
    logic [TAG_W-1:0] fill_tag_q;
    logic [WAY_W-1:0] vic_way_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;

    // Lookup
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way;
    logic             lookup, hit, miss, fill_done;
    logic [WAY_W-1:0] lru_victim;
    logic             victim_dirty;
    logic             unused_addr;

    assign req_off     = req_addr[2 +: OFF_W];
    assign req_idx     = req_addr[OFF_W + 2 +: IDX_W];
    assign req_tag     = req_addr[31 -: TAG_W];
    assign unused_addr = ^req_addr[1:0];

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign lookup    = req_valid && (state_q == IDLE);
    assign hit       = lookup && (|hit_vec);
    assign miss      = lookup && !(|hit_vec);
    assign fill_done = (state_q == FILL) && mem_ack;

    assign rsp_data  = hit ? data_q[req_idx][hit_way][req_off] : '0;
    // Gated by rst_n so a request held through reset does not report a stall.
    assign stall     = rst_n && (miss || (state_q != IDLE));

    assign victim_dirty = valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim];

    otter_cache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk             (clk),
        .rst_n           (rst_n),
        .lookup_set      (req_idx),
        .lookup_valid    (valid_q[req_idx]),
        .victim          (lru_victim),
        .touch_en        (hit || fill_done),
        .touch_set       (fill_done ? set_q : req_idx),
        .touch_way       (fill_done ? vic_way_q : hit_way),
        .touch_was_valid (fill_done ? valid_q[set_q][vic_way_q] : 1'b1)
    );

    // Miss FSM with registered memory-side outputs; the victim and set are
    // captured on the miss so they stay fixed while the core's request replays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            set_q      <= '0;
            fill_tag_q <= '0;
            vic_way_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        set_q      <= req_idx;
                        fill_tag_q <= req_tag;
                        vic_way_q  <= lru_victim;
                        mem_req_q  <= 1'b1;
                        if (victim_dirty) begin
                            state_q    <= WB;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {tag_q[req_idx][lru_victim], req_idx,
                                           {(OFF_W + 2){1'b0}}};
                        end else begin
                            state_q    <= FILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        state_q    <= FILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {fill_tag_q, set_q, {(OFF_W + 2){1'b0}}};
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wline = data_q[set_q][vic_way_q];

    // Valid and dirty bits; a zero byte-enable store is a hit that leaves the
    // line clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (fill_done) begin
                valid_q[set_q][vic_way_q] <= 1'b1;
                dirty_q[set_q][vic_way_q] <= 1'b0;
            end else if ((state_q == WB) && mem_ack) begin
                dirty_q[set_q][vic_way_q] <= 1'b0;
            end
            if (hit && req_we && (|req_be))
                dirty_q[req_idx][hit_way] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; cleared valid bits make their
    //       contents unreachable, and resetting them would cost a reset net on
    //       every storage bit.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[set_q][vic_way_q] <= mem_rline;
            tag_q[set_q][vic_way_q]  <= fill_tag_q;
        end else if (hit && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b])
                    data_q[req_idx][hit_way][req_off][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

`ifdef OTTER_DCACHE_STATS_EN
    // replay_q marks the IDLE cycle right after a fill, whose hit is the same
    // request that was already counted as a miss.
    logic replay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            replay_q <= 1'b0;
        end else begin
            if (fill_done)
                replay_q <= 1'b1;
            else if (state_q == IDLE)
                replay_q <= 1'b0;
            if (hit && !replay_q) hit_cnt  <= hit_cnt + 32'd1;
            if (miss)             miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_otter_dcache_sa.sv
// -----------------------------------------------------------------------------
// tb_otter_dcache_sa
// Self-checking bench for otter_dcache_sa at WAYS=2, SETS=16, LINE_WORDS=4.
// A golden word memory models the core's view; a backing memory answers line
// transfers. Expected load data, fills and write-backs are queued when the
// stimulus is issued and compared when the cache produces them.
// Define OTTER_DCACHE_STATS_EN to exercise hit_cnt / miss_cnt as well.
// -----------------------------------------------------------------------------
module tb_otter_dcache_sa;
    import otter_cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_be = '0;
    logic [31:0]  rsp_data;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wline;
    logic [127:0] mem_rline = '0;
    logic         mem_ack = 1'b0;
`ifdef OTTER_DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    otter_dcache_sa #(.WAYS(2), .SETS(16), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_data  (rsp_data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wline (mem_wline),
        .mem_rline (mem_rline),
        .mem_ack   (mem_ack)
`ifdef OTTER_DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        line_t       line;
    } wb_t;

    logic [31:0] bmem [1024];   // backing memory, word-addressed by addr[11:2]
    logic [31:0] gold [1024];   // architectural view seen by the core
    logic [31:0] exp_rsp  [$];
    logic [31:0] exp_fill [$];
    wb_t         exp_wb   [$];

    int n_checks = 0;
    int n_bad    = 0;
    int lat      = 2;           // memory answers on the (lat+1)-th cycle of a phase
    int wait_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Backing-memory responder.
    always @(negedge clk) begin
        logic  was_ack;
        line_t lf;
        was_ack = mem_ack;
        mem_ack = 1'b0;
        if (!rst_n || !mem_req) begin
            wait_cnt = 0;
        end else begin
            if (was_ack) wait_cnt = 0;
            if (wait_cnt >= lat) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    check("wb_expected", exp_wb.size() > 0, 1'b1);
                    if (exp_wb.size() > 0) begin
                        wb_t e;
                        e = exp_wb.pop_front();
                        check("wb_addr", mem_addr, e.addr);
                        check("wb_line", mem_wline, e.line);
                    end
                    lf = mem_wline;
                    for (int k = 0; k < 4; k++) bmem[{mem_addr[11:4], 2'(k)}] = lf[k];
                end else begin
                    check("fill_expected", exp_fill.size() > 0, 1'b1);
                    if (exp_fill.size() > 0) check("fill_addr", mem_addr, exp_fill.pop_front());
                    for (int k = 0; k < 4; k++) lf[k] = bmem[{mem_addr[11:4], 2'(k)}];
                    mem_rline = lf;
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic expect_fill(input logic [31:0] addr);
        exp_fill.push_back({addr[31:4], 4'h0});
    endtask

    task automatic expect_wb(input logic [31:0] addr);
        wb_t e;
        e.addr = {addr[31:4], 4'h0};
        for (int k = 0; k < 4; k++) e.line[k] = gold[{addr[11:4], 2'(k)}];
        exp_wb.push_back(e);
    endtask

    // One core access held until the cache stops stalling.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int exp_stalls);
        int          stalls;
        logic [31:0] w;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (we) begin
            w = gold[addr[11:2]];
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            gold[addr[11:2]] = w;
        end else begin
            exp_rsp.push_back(gold[addr[11:2]]);
        end
        #1;
        stalls = 0;
        while (stall && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stall) begin
            check({tag, "_timeout"}, stall, 1'b0);
            if (!we) void'(exp_rsp.pop_front());
        end else begin
            check({tag, "_stalls"}, stalls, exp_stalls);
            if (!we) check({tag, "_data"}, rsp_data, exp_rsp.pop_front());
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Dirty lines are lost on reset, so the core's view becomes memory's.
    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gold  = bmem;
    endtask

    function automatic int clean_miss(input int l);
        return l + 2;               // request cycle + (l+1) FILL cycles
    endfunction

    function automatic int dirty_miss(input int l);
        return 2 * l + 3;           // plus (l+1) WB cycles
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) bmem[i] = 32'hA500_0000 | (i * 4);
        bmem[32'h100 >> 2] = 32'hDEAD_BEEF;
        gold = bmem;

        // Reset values with a request already presented.
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        #11;
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp", rsp_data, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;

        // Clean miss then hit; byte store merges and dirties the line.
        expect_fill(32'h100);
        do_access("ld100_miss", 1'b0, 32'h100, '0, '0, clean_miss(lat));
        do_access("ld100_hit", 1'b0, 32'h100, '0, '0, 0);
        do_access("st104", 1'b1, 32'h104, 32'h0000_00AB, 4'b0001, 0);
        do_access("ld104", 1'b0, 32'h104, '0, '0, 0);
        // Evict the dirty 0x100 line to observe its merged contents.
        expect_fill(32'h000);
        do_access("ld000", 1'b0, 32'h000, '0, '0, clean_miss(lat));
        expect_wb(32'h100);
        expect_fill(32'h200);
        do_access("ld200_dirty", 1'b0, 32'h200, '0, '0, dirty_miss(lat));

        // LRU victim choice: 0x000 touched last, so 0x100 goes, no write-back.
        do_reset();
        expect_fill(32'h000);
        do_access("lru_ld000", 1'b0, 32'h000, '0, '0, clean_miss(lat));
        expect_fill(32'h100);
        do_access("lru_ld104", 1'b0, 32'h104, '0, '0, clean_miss(lat));
        do_access("lru_touch000", 1'b0, 32'h000, '0, '0, 0);
        expect_fill(32'h200);
        do_access("lru_ld200", 1'b0, 32'h200, '0, '0, clean_miss(lat));
        do_access("lru_keep000", 1'b0, 32'h000, '0, '0, 0);
        expect_fill(32'h100);
        do_access("lru_gone100", 1'b0, 32'h100, '0, '0, clean_miss(lat));

        // Dirty victim: store miss, second fill, then evict 0x000.
        do_reset();
        expect_fill(32'h000);
        do_access("dv_st000", 1'b1, 32'h000, 32'h5566_7788, 4'b1111, clean_miss(lat));
        expect_fill(32'h100);
        do_access("dv_ld100", 1'b0, 32'h100, '0, '0, clean_miss(lat));
        expect_wb(32'h000);
        expect_fill(32'h200);
        do_access("dv_ld200", 1'b0, 32'h200, '0, '0, dirty_miss(lat));
        do_access("dv_ld200_hit", 1'b0, 32'h200, '0, '0, 0);

        // Reset during FILL before the acknowledge.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h300;
        @(posedge clk);
        #1;
        check("mid_fill_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        gold      = bmem;
        expect_fill(32'h100);
        do_access("post_rst_ld100", 1'b0, 32'h100, '0, '0, clean_miss(lat));
        expect_fill(32'h000);
        do_access("post_rst_ld000", 1'b0, 32'h000, '0, '0, clean_miss(lat));

        // Zero-latency memory; a zero byte-enable store keeps the line clean.
        lat = 0;
        expect_fill(32'h340);
        do_access("z_ld340", 1'b0, 32'h340, '0, '0, clean_miss(lat));
        do_access("z_st340_be0", 1'b1, 32'h340, 32'hFFFF_FFFF, 4'b0000, 0);
        do_access("z_ld340_hit", 1'b0, 32'h340, '0, '0, 0);
        expect_fill(32'h440);
        do_access("z_ld440", 1'b0, 32'h440, '0, '0, clean_miss(lat));
        expect_fill(32'h540);
        do_access("z_ld540_clean", 1'b0, 32'h540, '0, '0, clean_miss(lat));

`ifdef OTTER_DCACHE_STATS_EN
        // Counters: 2 misses and 3 hits; replayed post-fill hits do not count.
        lat = 1;
        do_reset();
        check("cnt_rst_hit", hit_cnt, 32'd0);
        check("cnt_rst_miss", miss_cnt, 32'd0);
        expect_fill(32'h000);
        do_access("c_ld000", 1'b0, 32'h000, '0, '0, clean_miss(lat));
        do_access("c_ld000_hit", 1'b0, 32'h000, '0, '0, 0);
        expect_fill(32'h100);
        do_access("c_ld100", 1'b0, 32'h100, '0, '0, clean_miss(lat));
        do_access("c_ld100_hit", 1'b0, 32'h100, '0, '0, 0);
        do_access("c_ld000_hit2", 1'b0, 32'h000, '0, '0, 0);
        check("hit_cnt", hit_cnt, 32'd3);
        check("miss_cnt", miss_cnt, 32'd2);
`endif

        repeat (3) @(negedge clk);
        check("fill_q_left", exp_fill.size(), 0);
        check("wb_q_left", exp_wb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/otter_dcache_sa.md
# otter_dcache_sa

Parametrised N-way set-associative, write-back, write-allocate data cache for the OTTER RV32I memory subsystem. Sits between the core's data port (byte address, byte-enabled write data) and backing data memory, which it accesses one line at a time. It replaces the fixed-geometry data cache and the separate stall FSM with one block. That block owns its miss FSM, its true-LRU replacement and its stall output.

## Interface
- WAYS, 2 — associativity, power of two, 1..8
- SETS, 16 — sets, power of two, ≥2
- LINE_WORDS, 4 — 32-bit words per line, power of two, ≥2
- CLK  in  1  — clock, all state on rising edge
- RST_N  in  1  — asynchronous, active-low reset
- REQ_VALID  in  1  — core access request
- REQ_WE  in  1  — 1 = store, 0 = load
- REQ_ADDR  in  32  — byte address; bits [1:0] ignored
- REQ_WDATA  in  32  — store data, lane-aligned
- REQ_BE  in  4  — store byte enables
- RSP_DATA  out  32  — full loaded word; the memory top level sizes it
- STALL  out  1  — core must hold the request stable while high
- MEM_REQ  out  1  — line transfer request
- MEM_WE  out  1  — 1 = write back a line, 0 = fill a line
- MEM_ADDR  out  32  — line-aligned byte address
- MEM_WLINE  out  32*LINE_WORDS  — write-back line, word 0 in LSBs
- MEM_RLINE  in  32*LINE_WORDS  — fill line, sampled when MEM_ACK is high
- MEM_ACK  in  1  — one-cycle transfer completion

## Operation
- Address fields: offset = [log2(LINE_WORDS)+1:2], index = next log2(SETS) bits, tag = the remainder.
- Arrays are register-based, so lookup is combinational. Each line has a valid bit, a dirty bit and a tag. Each way in a set has an age of log2(WAYS) bits.
- FSM states:
  - IDLE: hit → no stall. Miss with dirty victim → WB. Miss with clean or invalid victim → FILL.
  - WB: goes to FILL on MEM_ACK.
  - FILL: goes to IDLE on MEM_ACK.
- Victim selection: the lowest-index invalid way; otherwise the way with the maximum age.
- Ages:
  - On a hit or a fill, the touched way's age becomes 0.
  - Ways younger than the touched way's old age increment.
  - Ages stay a permutation of 0..WAYS-1.
- Load hit: RSP_DATA = the selected word in the same cycle. RSP_DATA = 0 whenever there is no hit.
- Store hit: the enabled bytes are merged at the clock edge and dirty is set. Store with REQ_BE = 0 is a hit with no change, and dirty is not set.
- Store miss: fill the line, then the replayed IDLE lookup hits and merges.
- Fill writes the whole line, sets valid = 1 and dirty = 0, and stores the tag.
- Write-back: MEM_ADDR = {victim tag, index, 0}, MEM_WLINE = victim line. Victim dirty clears on ACK.
- STALL = REQ_VALID & miss in IDLE, or the state is WB or FILL.
- MEM_REQ = 1 throughout WB and FILL. MEM_WE = (state == WB).
- MEM_ACK is ignored in IDLE.
- REQ_VALID = 0 in IDLE: no state change and no age update.

## Timing
- Reset (async assert): every valid bit, dirty bit and age returns to 0, and state goes to IDLE. While in reset: STALL = 0, MEM_REQ = 0, MEM_WE = 0, MEM_ADDR = 0, RSP_DATA = 0.
- Hit: 0 stall cycles.
- Clean miss: STALL high from the request cycle through the FILL ACK cycle; hit on the next cycle. Total = 2 + memory latency.
- Dirty miss: adds the WB phase and its ACK cycle.
- MEM_ADDR and MEM_WE are stable while MEM_REQ is high. MEM_ACK in the same cycle as MEM_REQ's first assertion is legal.
- Reset mid-transfer: MEM_REQ drops asynchronously. The in-flight line is discarded and all lines are invalidated. Data that was dirty is lost by design.
- WAYS = 1 degenerates to direct-mapped, with no age state.

## Configuration
- OTTER_DCACHE_STATS_EN defined:
  - Adds outputs HIT_CNT[31:0] and MISS_CNT[31:0], both reset to 0.
  - Each counts once per request, evaluated in the IDLE cycle with REQ_VALID high.
  - A replayed post-fill hit is not counted as a hit. Counters wrap at 2^32.
- Undefined: no counter ports and no counter logic.

## Structure
- otter_cache_pkg holds:
  - the state enum (IDLE, WB, FILL);
  - field-width localparam functions for offset, index and tag;
  - a line_t typedef packed over LINE_WORDS.
- Sub-module otter_cache_lru holds per-set ages, victim selection and the age update, parametrised by WAYS and SETS.

## Test plan
- Reset, then load 0x100 with memory 0x100 = 0xDEADBEEF:
  - STALL and FILL are seen, then RSP_DATA = 0xDEADBEEF.
  - A repeat load hits with no stall.
- Store 0x0000_00AB with BE = 0001 to 0x104 on a hit line, then load 0x104: low byte = 0xAB, upper bytes unchanged, line dirty.
- WAYS = 2 and SETS = 16: fill 0x000 and 0x100 (same set), touch 0x000, then access 0x200 → the victim is the 0x100 way, clean, no WB.
- Dirty victim: store to 0x000, fill 0x100, then access 0x200 twice → WB with MEM_ADDR = 0x000 and the merged line, then FILL 0x200.
- Assert RST_N low during FILL before ACK → MEM_REQ = 0 immediately. After release, a load of 0x100 misses again.
- With OTTER_DCACHE_STATS_EN: 3 hits and 2 misses → HIT_CNT = 3, MISS_CNT = 2.
